time_entry_loader: RTL and testbench

- Keypad-side producer for the MM:SS down-counting timer chain, made of the MOD10 and MOD6 counter digits.
- Takes decimal key presses and shifts them, microwave style, into four BCD digits.
- Validates the entry and drives the counters' parallel inputs.
- Issues a one-cycle active-low load pulse that presets the timer before counting starts.

---
 rtl/time_entry_loader_if.sv | 22 ++
 rtl/time_entry_loader.sv | 141 ++++++++++++++
 tb/tb_time_entry_loader.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/time_entry_loader_if.sv
// Keypad/timer-side bundle for time_entry_loader: key events and busy in,
// BCD preset digits, load strobe and entry status out.
interface time_entry_loader_if;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        busy;
    logic [15:0] digits_out;
    logic        load;
    logic        entry_active;
    logic [2:0]  digit_count;
    logic        err;

    modport master (
        output key_valid, key_code, busy,
        input  digits_out, load, entry_active, digit_count, err
    );

    modport slave (
        input  key_valid, key_code, busy,
        output digits_out, load, entry_active, digit_count, err
    );
endinterface

// File: rtl/time_entry_loader.sv
// Microwave-style MM:SS keypad entry that presets the MOD10/MOD6 down-counter chain.
// Optional macro AUTO_NORMALIZE_EN: fold seconds >= 60 into minutes instead of rejecting.
module time_entry_loader #(
    parameter int SEC_TENS_MAX = 5,
    parameter int MAX_DIGITS   = 4
) (
    input  logic               clk,
    input  logic               clear,
    time_entry_loader_if.slave bus
);

    typedef enum logic [1:0] {IDLE, ENTRY, LOAD} state_t;

    localparam logic [3:0] SEC_TENS_LIM = 4'(SEC_TENS_MAX);
    localparam logic [2:0] MAX_CNT      = 3'(MAX_DIGITS);

    state_t state;
    logic   key_valid_q;
    logic   press;
    logic   is_digit;
    logic   is_cancel;
    logic   is_enter;
    logic   sec_over;

    // A held key only counts once, and busy swallows the edge rather than deferring it.
    assign press     = bus.key_valid & ~key_valid_q & ~bus.busy;
    assign is_digit  = (bus.key_code <= 4'd9);
    assign is_cancel = (bus.key_code == 4'hA);
    assign is_enter  = (bus.key_code == 4'hB);
    assign sec_over  = (bus.digits_out[7:4] > SEC_TENS_LIM);

`ifdef AUTO_NORMALIZE_EN
    logic        norm_pend;
    logic [16:0] norm_res;

    // Returns {ok, digits}; ok=0 when the minute carry would overflow 99.
    function automatic logic [16:0] normalize(input logic [15:0] d);
        logic [3:0] mt;
        logic [3:0] mu;
        logic [6:0] s;
        logic [6:0] r;
        mt = d[15:12];
        mu = d[11:8];
        s  = 7'(d[7:4]) * 7'd10 + 7'(d[3:0]);
        if (s < 7'd60)
            return {1'b1, d};
        if (mt == 4'd9 && mu == 4'd9)
            return {1'b0, d};
        r = s - 7'd60;
        if (mu == 4'd9) begin
            mu = 4'd0;
            mt = mt + 4'd1;
        end else begin
            mu = mu + 4'd1;
        end
        return {1'b1, mt, mu, 4'(r / 7'd10), 4'(r % 7'd10)};
    endfunction

    assign norm_res = normalize(bus.digits_out);
`endif

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state            <= IDLE;
            key_valid_q      <= 1'b0;
            bus.digits_out   <= 16'h0000;
            bus.load         <= 1'b1;
            bus.entry_active <= 1'b0;
            bus.digit_count  <= 3'd0;
            bus.err          <= 1'b0;
`ifdef AUTO_NORMALIZE_EN
            norm_pend        <= 1'b0;
`endif
        end else begin
            key_valid_q <= bus.key_valid;
            bus.err     <= 1'b0;
            case (state)
                IDLE: begin
                    if (press) begin
                        if (is_digit) begin
                            bus.digits_out   <= {12'h000, bus.key_code};
                            bus.digit_count  <= 3'd1;
                            bus.entry_active <= 1'b1;
                            state            <= ENTRY;
                        end else if (is_cancel) begin
                            bus.digits_out <= 16'h0000;
                        end
                    end
                end
                ENTRY: begin
`ifdef AUTO_NORMALIZE_EN
                    // Normalized digits get one settled cycle before the strobe.
                    if (norm_pend) begin
                        norm_pend        <= 1'b0;
                        bus.load         <= 1'b0;
                        bus.entry_active <= 1'b0;
                        state            <= LOAD;
                    end else
`endif
                    if (press) begin
                        if (is_digit) begin
                            if (bus.digit_count < MAX_CNT) begin
                                bus.digits_out  <= {bus.digits_out[11:0], bus.key_code};
                                bus.digit_count <= bus.digit_count + 3'd1;
                            end
                        end else if (is_cancel) begin
                            bus.digits_out   <= 16'h0000;
                            bus.digit_count  <= 3'd0;
                            bus.entry_active <= 1'b0;
                            state            <= IDLE;
                        end else if (is_enter) begin
                            if (!sec_over) begin
                                bus.load         <= 1'b0;
                                bus.entry_active <= 1'b0;
                                state            <= LOAD;
                            end else begin
`ifdef AUTO_NORMALIZE_EN
                                if (norm_res[16]) begin
                                    bus.digits_out <= norm_res[15:0];
                                    norm_pend      <= 1'b1;
                                end else begin
                                    bus.err <= 1'b1;
                                end
`else
                                bus.err <= 1'b1;
`endif
                            end
                        end
                    end
                end
                LOAD: begin
                    bus.load        <= 1'b1;
                    bus.digit_count <= 3'd0;
                    state           <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_time_entry_loader.sv
// Directed bench for time_entry_loader: cycle table plus hand sequences for
// the enter/normalize, overflow and clear-during-load corners.
module tb_time_entry_loader;

    logic clk = 1'b0;
    logic clear;
    int   n_vec = 0;
    int   n_bad = 0;

    time_entry_loader_if bus();

    time_entry_loader dut (
        .clk   (clk),
        .clear (clear),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        kv;
        logic [3:0]  code;
        logic        busy;
        logic [15:0] d;
        logic        ld;
        logic        ea;
        logic [2:0]  cnt;
        logic        er;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic kv, input logic [3:0] code, input logic b,
                       input logic [15:0] d, input logic ld, input logic ea,
                       input logic [2:0] cnt, input logic er);
        vec_t v;
        v.kv = kv; v.code = code; v.busy = b;
        v.d = d; v.ld = ld; v.ea = ea; v.cnt = cnt; v.er = er;
        tbl.push_back(v);
    endtask

    task automatic step(input logic kv, input logic [3:0] code, input logic b);
        bus.key_valid = kv;
        bus.key_code  = code;
        bus.busy      = b;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [15:0] d, input logic ld,
                         input logic ea, input logic [2:0] cnt, input logic er);
        n_vec++;
        if ({bus.digits_out, bus.load, bus.entry_active, bus.digit_count, bus.err}
            !== {d, ld, ea, cnt, er}) begin
            n_bad++;
            $display("FAIL %s: got digits=%h load=%b active=%b count=%0d err=%b, want digits=%h load=%b active=%b count=%0d err=%b",
                     nm, bus.digits_out, bus.load, bus.entry_active, bus.digit_count, bus.err,
                     d, ld, ea, cnt, er);
        end
    endtask

    initial begin
        // 1,3,0 enter
        add(1,4'h1,0, 16'h0001,1,1,1,0); add(0,4'h0,0, 16'h0001,1,1,1,0);
        add(1,4'h3,0, 16'h0013,1,1,2,0); add(0,4'h0,0, 16'h0013,1,1,2,0);
        add(1,4'h0,0, 16'h0130,1,1,3,0); add(0,4'h0,0, 16'h0130,1,1,3,0);
        add(1,4'hB,0, 16'h0130,0,0,3,0); add(0,4'h0,0, 16'h0130,1,0,0,0);
        add(0,4'h0,0, 16'h0130,1,0,0,0);
        // 1..5, fifth ignored, enter
        add(1,4'h1,0, 16'h0001,1,1,1,0); add(0,4'h0,0, 16'h0001,1,1,1,0);
        add(1,4'h2,0, 16'h0012,1,1,2,0); add(0,4'h0,0, 16'h0012,1,1,2,0);
        add(1,4'h3,0, 16'h0123,1,1,3,0); add(0,4'h0,0, 16'h0123,1,1,3,0);
        add(1,4'h4,0, 16'h1234,1,1,4,0); add(0,4'h0,0, 16'h1234,1,1,4,0);
        add(1,4'h5,0, 16'h1234,1,1,4,0); add(0,4'h0,0, 16'h1234,1,1,4,0);
        add(1,4'hB,0, 16'h1234,0,0,4,0); add(0,4'h0,0, 16'h1234,1,0,0,0);
        // 5 then cancel
        add(1,4'h5,0, 16'h0005,1,1,1,0); add(0,4'h0,0, 16'h0005,1,1,1,0);
        add(1,4'hA,0, 16'h0000,1,0,0,0); add(0,4'h0,0, 16'h0000,1,0,0,0);
        // key 7 held for 10 cycles
        for (int i = 0; i < 10; i++) add(1,4'h7,0, 16'h0007,1,1,1,0);
        add(0,4'h0,0, 16'h0007,1,1,1,0);
        add(1,4'hA,0, 16'h0000,1,0,0,0); add(0,4'h0,0, 16'h0000,1,0,0,0);
        // busy blocks presses in IDLE; edge consumed while busy
        add(1,4'h4,1, 16'h0000,1,0,0,0); add(0,4'h0,1, 16'h0000,1,0,0,0);
        add(1,4'hB,1, 16'h0000,1,0,0,0); add(0,4'h0,1, 16'h0000,1,0,0,0);
        add(1,4'h4,1, 16'h0000,1,0,0,0); add(1,4'h4,0, 16'h0000,1,0,0,0);
        add(0,4'h0,0, 16'h0000,1,0,0,0);
        add(1,4'h4,0, 16'h0004,1,1,1,0); add(0,4'h0,0, 16'h0004,1,1,1,0);
        add(1,4'hB,0, 16'h0004,0,0,1,0); add(1,4'h8,0, 16'h0004,1,0,0,0);
        add(0,4'h0,0, 16'h0004,1,0,0,0);
        // ignored codes, enter and cancel in IDLE
        add(1,4'hC,0, 16'h0004,1,0,0,0); add(0,4'h0,0, 16'h0004,1,0,0,0);
        add(1,4'hB,0, 16'h0004,1,0,0,0); add(0,4'h0,0, 16'h0004,1,0,0,0);
        add(1,4'hA,0, 16'h0000,1,0,0,0); add(0,4'h0,0, 16'h0000,1,0,0,0);
        // busy mid-entry freezes
        add(1,4'h6,0, 16'h0006,1,1,1,0); add(0,4'h0,0, 16'h0006,1,1,1,0);
        add(1,4'h7,1, 16'h0006,1,1,1,0); add(0,4'h0,1, 16'h0006,1,1,1,0);
        add(1,4'hF,0, 16'h0006,1,1,1,0); add(0,4'h0,0, 16'h0006,1,1,1,0);
        add(1,4'h7,0, 16'h0067,1,1,2,0); add(0,4'h0,0, 16'h0067,1,1,2,0);
        add(1,4'hA,0, 16'h0000,1,0,0,0); add(0,4'h0,0, 16'h0000,1,0,0,0);

        clear         = 1'b0;
        bus.key_valid = 1'b0;
        bus.key_code  = 4'h0;
        bus.busy      = 1'b0;
        #12;
        check("reset", 16'h0000, 1, 0, 0, 0);
        clear = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].kv, tbl[i].code, tbl[i].busy);
            check($sformatf("vec%0d", i), tbl[i].d, tbl[i].ld, tbl[i].ea, tbl[i].cnt, tbl[i].er);
        end

        // 9,0 enter: seconds 90
        step(1,4'h9,0); check("s90_d9", 16'h0009,1,1,1,0);
        step(0,4'h0,0);
        step(1,4'h0,0); check("s90_d0", 16'h0090,1,1,2,0);
        step(0,4'h0,0);
        step(1,4'hB,0);
`ifdef AUTO_NORMALIZE_EN
        check("s90_norm", 16'h0130,1,1,2,0);
        step(0,4'h0,0); check("s90_load", 16'h0130,0,0,2,0);
        step(0,4'h0,0); check("s90_idle", 16'h0130,1,0,0,0);
        step(1,4'hA,0); check("s90_cancel", 16'h0000,1,0,0,0);
`else
        check("s90_err", 16'h0090,1,1,2,1);
        step(0,4'h0,0); check("s90_err_end", 16'h0090,1,1,2,0);
        step(1,4'hA,0); check("s90_cancel", 16'h0000,1,0,0,0);
`endif
        step(0,4'h0,0);

        // 99:70 cannot carry: rejected on both builds
        step(1,4'h9,0); step(0,4'h0,0);
        step(1,4'h9,0); step(0,4'h0,0);
        step(1,4'h7,0); step(0,4'h0,0);
        step(1,4'h0,0); step(0,4'h0,0); check("m99_digits", 16'h9970,1,1,4,0);
        step(1,4'hB,0); check("m99_err", 16'h9970,1,1,4,1);
        step(0,4'h0,0); check("m99_err_end", 16'h9970,1,1,4,0);
        step(1,4'hA,0); check("m99_cancel", 16'h0000,1,0,0,0);
        step(0,4'h0,0);

        // 19:65 carries the minute units
        step(1,4'h1,0); step(0,4'h0,0);
        step(1,4'h9,0); step(0,4'h0,0);
        step(1,4'h6,0); step(0,4'h0,0);
        step(1,4'h5,0); step(0,4'h0,0); check("c1965_digits", 16'h1965,1,1,4,0);
        step(1,4'hB,0);
`ifdef AUTO_NORMALIZE_EN
        check("c1965_norm", 16'h2005,1,1,4,0);
        step(0,4'h0,0); check("c1965_load", 16'h2005,0,0,4,0);
        step(0,4'h0,0); check("c1965_idle", 16'h2005,1,0,0,0);
`else
        check("c1965_err", 16'h1965,1,1,4,1);
        step(0,4'h0,0); check("c1965_err_end", 16'h1965,1,1,4,0);
`endif
        step(1,4'hA,0); check("c1965_cancel", 16'h0000,1,0,0,0);
        step(0,4'h0,0);

        // clear during the LOAD cycle
        step(1,4'h1,0); check("clr_d1", 16'h0001,1,1,1,0);
        step(0,4'h0,0);
        step(1,4'hB,0); check("clr_load", 16'h0001,0,0,1,0);
        bus.key_valid = 1'b0;
        #2 clear = 1'b0;
        #1 check("clr_async", 16'h0000,1,0,0,0);
        #2 clear = 1'b1;
        @(posedge clk);
        #1 check("clr_after", 16'h0000,1,0,0,0);
        step(1,4'h2,0); check("clr_d2", 16'h0002,1,1,1,0);
        step(0,4'h0,0); check("clr_d2_hold", 16'h0002,1,1,1,0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
